// File: rtl/pending_size_monitor_pkg.sv
// Shared constants and types for the pending-size monitor: error codes,
// sticky-bit positions and the checker FSM states.
package pending_size_monitor_pkg;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
  localparam logic [1:0] ERR_MISMATCH  = 2'b11;

  // Bit positions inside each channel's 3-bit sticky field
  localparam int STK_UF = 0;
  localparam int STK_OF = 1;
  localparam int STK_MM = 2;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    RUN     = 2'd1,
    TRIPPED = 2'd2
  } state_t;

endpackage

// File: rtl/pending_size_monitor_ch.sv
// One monitored channel: shadow count, high-water mark and combinational
// underflow / overflow / mismatch detection for the current cycle.
module pending_size_monitor_ch
  import pending_size_monitor_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int INCRW = 8,
  parameter int DECRW = 8,
  parameter int SIZEW = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [INCRW-1:0] i_incr,
  input  logic [DECRW-1:0] i_decr,
  input  logic [SIZEW-1:0] i_size,
  input  logic             i_mm_en,
  output logic [SIZEW-1:0] o_shadow,
  output logic [SIZEW-1:0] o_high_water,
  output logic             o_uf,
  output logic             o_of,
  output logic             o_mm
);

  localparam int SW = SIZEW + ((INCRW > DECRW) ? INCRW : DECRW) + 2;
  localparam logic signed [SW-1:0] W_LIM = SW'(SIZE);

  logic [SIZEW-1:0]        r_shadow;
  logic [SIZEW-1:0]        r_high_water;
  logic signed [SW-1:0]    w_sum;
  logic [SIZEW-1:0]        w_shadow_nxt;

  always_comb begin
    w_sum = $signed({{(SW-SIZEW){1'b0}}, r_shadow})
          + $signed({{(SW-INCRW){1'b0}}, i_incr})
          - $signed({{(SW-DECRW){1'b0}}, i_decr});
    o_uf = (w_sum < 0);
    o_of = !o_uf && (w_sum > W_LIM);
    // Saturate at the legal range so one bad cycle does not cascade
    if (o_uf)      w_shadow_nxt = '0;
    else if (o_of) w_shadow_nxt = SIZEW'(SIZE);
    else           w_shadow_nxt = w_sum[SIZEW-1:0];
    o_mm = i_mm_en && (i_size != r_shadow);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_shadow     <= '0;
      r_high_water <= '0;
    end else begin
      r_shadow <= w_shadow_nxt;
      if (w_shadow_nxt > r_high_water) r_high_water <= w_shadow_nxt;
    end
  end

  assign o_shadow     = r_shadow;
  assign o_high_water = r_high_water;

endmodule

// File: rtl/pending_size_monitor.sv
// Multi-channel pending-size checker: FSM, cycle stamp and first-error capture.
// Define PENDING_SIZE_MONITOR_LOG_EN for simulation event/error logging.
module pending_size_monitor
  import pending_size_monitor_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SIZE   = 16,
  parameter int INCRW  = 8,
  parameter int DECRW  = 8,
  localparam int SIZEW = $clog2(SIZE + 1),
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*INCRW-1:0] ch_incr,
  input  logic [NUM_CH*DECRW-1:0] ch_decr,
  input  logic [NUM_CH*SIZEW-1:0] ch_size,
  input  logic                    clear,
  output logic [NUM_CH*SIZEW-1:0] shadow_size,
  output logic [NUM_CH*SIZEW-1:0] high_water,
  output logic [NUM_CH*3-1:0]     err_sticky,
  output logic                    err_valid,
  output logic [CHW-1:0]          err_ch,
  output logic [1:0]              err_code,
  output logic [31:0]             err_cycle
);

  state_t              r_state, w_state_nxt;
  logic [31:0]         r_cycle;
  logic [NUM_CH*3-1:0] r_sticky;
  logic                r_err_valid;
  logic [CHW-1:0]      r_err_ch;
  logic [1:0]          r_err_code;
  logic [31:0]         r_err_cycle;

  logic [NUM_CH*3-1:0] w_evt;
  logic                w_mm_en;
  logic                w_any;
  logic [CHW-1:0]      w_sel_ch;
  logic [1:0]          w_sel_code;
  logic                w_capture;
  logic                w_clr;

  assign w_mm_en = (r_state != WARMUP);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pending_size_monitor_ch #(
      .SIZE (SIZE),
      .INCRW(INCRW),
      .DECRW(DECRW),
      .SIZEW(SIZEW)
    ) u_ch (
      .clk         (clk),
      .i_reset     (reset),
      .i_incr      (ch_incr[g*INCRW +: INCRW]),
      .i_decr      (ch_decr[g*DECRW +: DECRW]),
      .i_size      (ch_size[g*SIZEW +: SIZEW]),
      .i_mm_en     (w_mm_en),
      .o_shadow    (shadow_size[g*SIZEW +: SIZEW]),
      .o_high_water(high_water[g*SIZEW +: SIZEW]),
      .o_uf        (w_evt[g*3 + STK_UF]),
      .o_of        (w_evt[g*3 + STK_OF]),
      .o_mm        (w_evt[g*3 + STK_MM])
    );
  end

  // Walk downwards so the lowest erroring channel is the one left selected
  always_comb begin
    w_any      = 1'b0;
    w_sel_ch   = '0;
    w_sel_code = ERR_NONE;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (|w_evt[i*3 +: 3]) begin
        w_any    = 1'b1;
        w_sel_ch = CHW'(i);
        if (w_evt[i*3 + STK_UF])      w_sel_code = ERR_UNDERFLOW;
        else if (w_evt[i*3 + STK_OF]) w_sel_code = ERR_OVERFLOW;
        else                          w_sel_code = ERR_MISMATCH;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      WARMUP: begin
        w_state_nxt = RUN;
        if (w_any) begin
          w_capture   = 1'b1;
          w_state_nxt = TRIPPED;
        end
      end
      RUN: begin
        if (clear) begin
          w_clr = 1'b1;
        end else if (w_any) begin
          w_capture   = 1'b1;
          w_state_nxt = TRIPPED;
        end
      end
      TRIPPED: begin
        if (clear) begin
          w_clr       = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = WARMUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= WARMUP;
      r_cycle     <= '0;
      r_sticky    <= '0;
      r_err_valid <= 1'b0;
      r_err_ch    <= '0;
      r_err_code  <= ERR_NONE;
      r_err_cycle <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cycle <= r_cycle + 32'd1;
      if (w_clr) begin
        r_sticky    <= '0;
        r_err_valid <= 1'b0;
        r_err_ch    <= '0;
        r_err_code  <= ERR_NONE;
        r_err_cycle <= '0;
      end else begin
        r_sticky <= r_sticky | w_evt;
        if (w_capture) begin
          r_err_valid <= 1'b1;
          r_err_ch    <= w_sel_ch;
          r_err_code  <= w_sel_code;
          r_err_cycle <= r_cycle;
        end
      end
    end
  end

  assign err_sticky = r_sticky;
  assign err_valid  = r_err_valid;
  assign err_ch     = r_err_ch;
  assign err_code   = r_err_code;
  assign err_cycle  = r_err_cycle;

`ifdef PENDING_SIZE_MONITOR_LOG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((ch_incr[i*INCRW +: INCRW] != '0) || (ch_decr[i*DECRW +: DECRW] != '0))
          $display("%m t=%0t ch=%0d shadow=%0d incr=%0d decr=%0d", $time, i,
                   shadow_size[i*SIZEW +: SIZEW], ch_incr[i*INCRW +: INCRW],
                   ch_decr[i*DECRW +: DECRW]);
      end
      if (w_capture)
        $display("%m t=%0t first error ch=%0d code=%0b cycle=%0d", $time,
                 w_sel_ch, w_sel_code, r_cycle);
    end
  end
`endif

endmodule

// File: tb/tb_pending_size_monitor.sv
// Randomized self-checking bench for pending_size_monitor against a
// behavioural model, plus directed boundary scenarios.
module tb_pending_size_monitor;

  localparam int NCH  = 4;
  localparam int SIZE = 16;
  localparam int IW   = 8;
  localparam int DW   = 8;
  localparam int SW   = 5;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH*IW-1:0] ch_incr;
  logic [NCH*DW-1:0] ch_decr;
  logic [NCH*SW-1:0] ch_size;
  logic              clear;
  logic [NCH*SW-1:0] shadow_size;
  logic [NCH*SW-1:0] high_water;
  logic [NCH*3-1:0]  err_sticky;
  logic              err_valid;
  logic [CW-1:0]     err_ch;
  logic [1:0]        err_code;
  logic [31:0]       err_cycle;

  pending_size_monitor #(.NUM_CH(NCH), .SIZE(SIZE), .INCRW(IW), .DECRW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_incr    (ch_incr),
    .ch_decr    (ch_decr),
    .ch_size    (ch_size),
    .clear      (clear),
    .shadow_size(shadow_size),
    .high_water (high_water),
    .err_sticky (err_sticky),
    .err_valid  (err_valid),
    .err_ch     (err_ch),
    .err_code   (err_code),
    .err_cycle  (err_cycle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int          m_sh[NCH];
  int          m_hw[NCH];
  bit [2:0]    m_stk[NCH];
  bit          m_warm;
  bit          m_valid;
  int          m_ch, m_code;
  int unsigned m_cnt, m_cap;

  // Per-cycle stimulus
  int d_inc[NCH], d_dec[NCH], d_sz[NCH];
  bit d_mm[NCH];
  bit d_clr, d_rst;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit       any;
    int       fch, fcode, s;
    bit [2:0] ev[NCH];
    any = 0; fch = 0; fcode = 0;
    if (d_rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_sh[i] = 0; m_hw[i] = 0; m_stk[i] = 0;
      end
      m_warm = 1; m_valid = 0; m_ch = 0; m_code = 0; m_cnt = 0; m_cap = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ev[i] = 3'b000;
        if (!m_warm && d_sz[i] != m_sh[i]) ev[i][2] = 1'b1;
        s = m_sh[i] + d_inc[i] - d_dec[i];
        if (s < 0) begin ev[i][0] = 1'b1; s = 0; end
        else if (s > SIZE) begin ev[i][1] = 1'b1; s = SIZE; end
        m_sh[i] = s;
        if (s > m_hw[i]) m_hw[i] = s;
        if (ev[i] != 0 && !any) begin
          any = 1; fch = i;
          fcode = ev[i][0] ? 1 : (ev[i][1] ? 2 : 3);
        end
      end
      if (d_clr && !m_warm) begin
        for (int i = 0; i < NCH; i++) m_stk[i] = 0;
        m_valid = 0; m_ch = 0; m_code = 0; m_cap = 0;
      end else begin
        for (int i = 0; i < NCH; i++) m_stk[i] |= ev[i];
        if (!m_valid && any) begin
          m_valid = 1; m_ch = fch; m_code = fcode; m_cap = m_cnt;
        end
      end
      m_warm = 0;
      m_cnt  = m_cnt + 1;
    end
  endtask

  task automatic check_all();
    logic [NCH*SW-1:0] e_sh, e_hw;
    logic [NCH*3-1:0]  e_stk;
    for (int i = 0; i < NCH; i++) begin
      e_sh[i*SW +: SW] = SW'(m_sh[i]);
      e_hw[i*SW +: SW] = SW'(m_hw[i]);
      e_stk[i*3 +: 3]  = m_stk[i];
    end
    chk("shadow_size", 64'(shadow_size), 64'(e_sh));
    chk("high_water", 64'(high_water), 64'(e_hw));
    chk("err_sticky", 64'(err_sticky), 64'(e_stk));
    chk("err_valid", 64'(err_valid), 64'(m_valid));
    chk("err_ch", 64'(err_ch), 64'(m_ch));
    chk("err_code", 64'(err_code), 64'(m_code));
    chk("err_cycle", 64'(err_cycle), 64'(m_cap));
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      d_sz[i] = d_mm[i] ? (m_sh[i] ^ 1) : m_sh[i];
      ch_incr[i*IW +: IW] = IW'(d_inc[i]);
      ch_decr[i*DW +: DW] = DW'(d_dec[i]);
      ch_size[i*SW +: SW] = SW'(d_sz[i]);
    end
    clear = d_clr;
    reset = d_rst;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    for (int i = 0; i < NCH; i++) begin
      d_inc[i] = 0; d_dec[i] = 0; d_mm[i] = 0;
    end
    d_clr = 0;
    d_rst = 0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; ch_incr = '0; ch_decr = '0; ch_size = '0;
    for (int i = 0; i < NCH; i++) begin
      d_inc[i] = 0; d_dec[i] = 0; d_mm[i] = 0; d_sz[i] = 0;
      m_sh[i] = 0; m_hw[i] = 0; m_stk[i] = 0;
    end
    d_clr = 0; m_warm = 1; m_valid = 0; m_ch = 0; m_code = 0; m_cnt = 0; m_cap = 0;

    d_rst = 1; step();
    d_rst = 1; step();
    chk("rst_shadow", 64'(shadow_size), 0);
    chk("rst_hw", 64'(high_water), 0);
    chk("rst_valid", 64'(err_valid), 0);
    chk("rst_cycle", 64'(err_cycle), 0);

    // Ch0 counts up to 5 with ch_size tracking
    for (int k = 0; k < 5; k++) begin d_inc[0] = 1; step(); end
    chk("t1_shadow0", 64'(shadow_size[4:0]), 5);
    chk("t1_hw0", 64'(high_water[4:0]), 5);
    chk("t1_valid", 64'(err_valid), 0);

    // Ch2 underflow at cycle 10
    for (int k = 0; k < 5; k++) step();
    d_dec[2] = 1; step();
    chk("t2_shadow2", 64'(shadow_size[14:10]), 0);
    chk("t2_uf_stk", 64'(err_sticky[6]), 1);
    chk("t2_ch", 64'(err_ch), 2);
    chk("t2_code", 64'(err_code), 1);
    chk("t2_cycle", 64'(err_cycle), 10);

    d_clr = 1; step();
    chk("clr_valid", 64'(err_valid), 0);
    chk("clr_sticky", 64'(err_sticky), 0);

    // Ch1 overflow 15 + 3 saturates at 16
    d_inc[1] = 15; step();
    d_inc[1] = 3; step();
    chk("t3_shadow1", 64'(shadow_size[9:5]), 16);
    chk("t3_of_stk", 64'(err_sticky[4]), 1);
    chk("t3_ch", 64'(err_ch), 1);
    chk("t3_code", 64'(err_code), 2);

    // Error coincident with clear is dropped
    d_clr = 1; step();
    d_clr = 1; d_dec[2] = 1; step();
    chk("drop_sticky", 64'(err_sticky), 0);
    chk("drop_valid", 64'(err_valid), 0);

    // Ch0 mismatch and ch3 overflow together: lowest channel wins
    d_mm[0] = 1; d_inc[3] = 17; step();
    chk("t4_ch", 64'(err_ch), 0);
    chk("t4_code", 64'(err_code), 3);
    chk("t4_mm_stk0", 64'(err_sticky[2]), 1);
    chk("t4_of_stk3", 64'(err_sticky[10]), 1);

    d_clr = 1; step();
    chk("t5_valid", 64'(err_valid), 0);
    chk("t5_sticky", 64'(err_sticky), 0);
    chk("t5_shadows", 64'(shadow_size), 64'({5'd16, 5'd0, 5'd16, 5'd5}));
    d_dec[2] = 1; step();
    chk("t5_run_valid", 64'(err_valid), 1);
    chk("t5_run_code", 64'(err_code), 1);

    d_rst = 1; step();
    chk("t6_shadow", 64'(shadow_size), 0);
    chk("t6_hw", 64'(high_water), 0);
    chk("t6_sticky", 64'(err_sticky), 0);
    chk("t6_valid", 64'(err_valid), 0);
    chk("t6_cycle", 64'(err_cycle), 0);

    // Mismatch suppressed only in the warm-up cycle
    d_mm[1] = 1; step();
    chk("wu_valid", 64'(err_valid), 0);
    chk("wu_sticky", 64'(err_sticky), 0);
    d_mm[1] = 1; step();
    chk("wu2_ch", 64'(err_ch), 1);
    chk("wu2_code", 64'(err_code), 3);
    chk("wu2_cycle", 64'(err_cycle), 1);

    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NCH; i++) begin
        d_inc[i] = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2);
        d_dec[i] = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2);
        d_mm[i]  = ($urandom_range(0, 29) == 0);
      end
      d_clr = ($urandom_range(0, 19) == 0);
      d_rst = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
